// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   General-purpose register file for the pipelined MIPS core, with a
//   per-register busy scoreboard. Decode reads source operands and claims a
//   destination at issue; writeback stores the result and releases the claim.
//   Register 0 is hardwired to zero and is never busy.
//
// Ports
//   CLK, reset            clock (rising edge), synchronous active-high reset
//   rd_addr1/2            read port addresses
//   rd_data1/2            read data (combinational, optional write bypass)
//   rd_busy1/2            source has an outstanding claim not released this cycle
//   wr_en/wr_addr/wr_data writeback port
//   claim_en/claim_addr   issue-time destination claim request
//   claim_ok              claim accepted this cycle (combinational)
//   busy_count            number of busy registers (registered)
module regfile_scoreboard #(
    parameter int W      = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1,
    parameter int CW     = 6
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic [W-1:0]  rd_data1,
    output logic [W-1:0]  rd_data2,
    output logic          rd_busy1,
    output logic          rd_busy2,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          claim_en,
    input  logic [AW-1:0] claim_addr,
    output logic          claim_ok,
    output logic [CW-1:0] busy_count
);

    localparam bit BYP = (BYPASS != 0);

    logic [W-1:0]    regs [NREG];
    logic [NREG-1:0] busy;

    logic wr_act;     // write that actually lands in the array
    logic claim_act;  // accepted claim on a real register
    logic inc;        // a busy bit goes 0 -> 1
    logic dec;        // a busy bit goes 1 -> 0
    logic fwd1;
    logic fwd2;

    always_comb begin
        wr_act    = wr_en && (wr_addr != '0);
        claim_ok  = claim_en && ((claim_addr == '0) || !busy[claim_addr]
                                 || (wr_en && (wr_addr == claim_addr)));
        claim_act = claim_ok && (claim_addr != '0);
        // A claim landing on a register being released in the same cycle keeps
        // the bit set, so neither the increment nor the decrement applies.
        inc = claim_act && !busy[claim_addr];
        dec = wr_act && busy[wr_addr] && !(claim_act && (claim_addr == wr_addr));
    end

    always_comb begin
        fwd1 = BYP && wr_act && (wr_addr == rd_addr1);
        fwd2 = BYP && wr_act && (wr_addr == rd_addr2);

        rd_data1 = '0;
        rd_busy1 = 1'b0;
        if (rd_addr1 != '0) begin
            rd_data1 = fwd1 ? wr_data : regs[rd_addr1];
            rd_busy1 = busy[rd_addr1] && !fwd1;
        end

        rd_data2 = '0;
        rd_busy2 = 1'b0;
        if (rd_addr2 != '0) begin
            rd_data2 = fwd2 ? wr_data : regs[rd_addr2];
            rd_busy2 = busy[rd_addr2] && !fwd2;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int unsigned i = 0; i < unsigned'(NREG); i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_act) begin
                regs[wr_addr] <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            // Later assignment wins: a same-register claim overrides the release.
            if (claim_act) begin
                busy[claim_addr] <= 1'b1;
            end
            busy_count <= busy_count + CW'(inc) - CW'(dec);
        end
    end

endmodule
